// File: rtl/word_fetch_controller.sv
// Fetches one random word: requests an index from the generator, validates it
// (range, no immediate repeat, bounded retries), then reads its letters from a registered ROM.
module word_fetch_controller #(
    parameter int WORD_COUNT = 100,
    parameter int WORD_LEN   = 5,
    parameter int CHAR_W     = 5,
    parameter int MAX_RETRY  = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    output logic                       grab_word_o,
    input  logic [6:0]                 random_num_i,
    output logic [8:0]                 rom_addr_o,
    input  logic [CHAR_W-1:0]          rom_data_i,
    output logic [WORD_LEN*CHAR_W-1:0] word_o,
    output logic [6:0]                 word_index_o,
    output logic                       word_valid_o,
    output logic                       busy_o,
    output logic                       error_o
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int KW = $clog2(WORD_LEN + 1);

    typedef enum logic [2:0] {IDLE, REQ, SAMPLE, CHECK, FETCH, DONE, ERR} state_t;

    state_t                       state_q;
    logic [6:0]                   cand_q;
    logic [6:0]                   prev_index_q;
    logic                         have_prev_q;
    logic [RW-1:0]                retry_q;
    logic [KW-1:0]                k_q;
    logic                         grab_word_q;
    logic [8:0]                   rom_addr_q;
    logic [WORD_LEN*CHAR_W-1:0]   word_q;
    logic [6:0]                   word_index_q;
    logic                         word_valid_q;
    logic                         busy_q;
    logic                         error_q;

    logic                         reject_d;
    logic [8:0]                   base_d;

    assign reject_d = (cand_q == 7'd0) ||
                      (32'(cand_q) > 32'(WORD_COUNT)) ||
                      (have_prev_q && (cand_q == prev_index_q));
    assign base_d   = (9'(cand_q) - 9'd1) * 9'(WORD_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            prev_index_q <= '0;
            have_prev_q  <= 1'b0;
            retry_q      <= '0;
            k_q          <= '0;
            grab_word_q  <= 1'b0;
            rom_addr_q   <= '0;
            word_q       <= '0;
            word_index_q <= '0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q      <= REQ;
                        grab_word_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        word_valid_q <= 1'b0;
                        error_q      <= 1'b0;
                        retry_q      <= '0;
                    end
                end
                REQ: begin
                    grab_word_q <= 1'b0;
                    state_q     <= SAMPLE;
                end
                SAMPLE: begin
                    cand_q  <= random_num_i;
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (reject_d) begin
                        if (retry_q == RW'(MAX_RETRY)) begin
                            state_q      <= ERR;
                            error_q      <= 1'b1;
                            word_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            retry_q     <= retry_q + 1'b1;
                            grab_word_q <= 1'b1;
                            state_q     <= REQ;
                        end
                    end else begin
                        word_index_q <= cand_q;
                        rom_addr_q   <= base_d;
                        k_q          <= '0;
                        state_q      <= FETCH;
                    end
                end
                FETCH: begin
                    // k_q counts FETCH cycles; letter i arrives from the ROM when k_q == i+1
                    if (k_q < KW'(WORD_LEN - 1))
                        rom_addr_q <= rom_addr_q + 9'd1;
                    for (int i = 0; i < WORD_LEN; i++) begin
                        if (k_q == KW'(i + 1))
                            word_q[i*CHAR_W +: CHAR_W] <= rom_data_i;
                    end
                    if (k_q == KW'(WORD_LEN)) begin
                        state_q      <= DONE;
                        word_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        prev_index_q <= word_index_q;
                        have_prev_q  <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grab_word_o  = grab_word_q;
    assign rom_addr_o   = rom_addr_q;
    assign word_o       = word_q;
    assign word_index_o = word_index_q;
    assign word_valid_o = word_valid_q;
    assign busy_o       = busy_q;
    assign error_o      = error_q;
endmodule
